// File: rtl/uart_tx_if.sv
// uart_tx_if: byte-write handshake between a producer and the UART transmitter.
//   data_in    : byte to transmit (producer -> transmitter)
//   send       : write strobe, byte taken on an edge where send=1 and ready=1
//   ready      : transmitter FIFO not full (transmitter -> producer)
//   fifo_count : bytes queued, excluding the byte currently being shifted out
// master = producer side, slave = transmitter side.
interface uart_tx_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int FC_W = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]      data_in;
  logic            send;
  logic            ready;
  logic [FC_W-1:0] fifo_count;

  modport master (output data_in, output send, input ready, input fifo_count);
  modport slave  (input data_in, input send, output ready, output fifo_count);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a small transmit FIFO.
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   bus     : uart_tx_if.slave (data_in, send, ready, fifo_count)
//   tx      : serial line, registered, idle high
//   tx_busy : high while a frame is on the line
//   done    : one-cycle pulse during the last clock of each stop bit
// FIFO_DEPTH must be a power of two (>= 2) so the pointers wrap by overflow.
// tx/tx_busy are registered from the FSM state, so the line lags the state by
// one clock; that lag is what places the start bit two clocks after a push
// into an idle, empty transmitter.
module uart_tx #(
  parameter int CLK_FREQ   = 1_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_tx_if.slave bus,
  output logic     tx,
  output logic     tx_busy,
  output logic     done
);
  localparam int BIT_PERIOD = CLK_FREQ / BAUD_RATE;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int FC_W       = PTR_W + 1;
  localparam int CNT_W      = ($clog2(BIT_PERIOD) > 16) ? $clog2(BIT_PERIOD) : 16;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [FC_W-1:0]  FC_ZERO  = FC_W'(0);
  localparam logic [FC_W-1:0]  FC_ONE   = FC_W'(1);
  localparam logic [FC_W-1:0]  FC_FULL  = FC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic             tx_r;
  logic             busy_r;
  logic             done_r;

  logic [7:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [FC_W-1:0]  count_r;

  logic             ready_s;
  logic             push_s;
  logic             pop_s;
  logic             bit_end_s;
  logic [7:0]       head_s;

  // Handshake, FIFO head and the pop decision (idle start or chained frame).
  always_comb begin
    ready_s   = (count_r < FC_FULL);
    push_s    = bus.send & ready_s;
    head_s    = mem_r[rd_ptr_r];
    bit_end_s = (cnt_r == CNT_LAST);
    pop_s     = 1'b0;
    case (state_r)
      IDLE:    pop_s = (count_r != FC_ZERO);
      STOP:    pop_s = bit_end_s && (count_r != FC_ZERO);
      default: pop_s = 1'b0;
    endcase
  end

  assign bus.ready      = ready_s;
  assign bus.fifo_count = count_r;
  assign tx             = tx_r;
  assign tx_busy        = busy_r;
  assign done           = done_r;

  // Byte storage; written only on an accepting edge so later data_in changes never reach it.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= bus.data_in;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= FC_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + FC_ONE;
        2'b01:   count_r <= count_r - FC_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Frame FSM with registered line outputs; each state drives the line one clock later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          tx_r      <= 1'b1;
          busy_r    <= 1'b0;
          cnt_r     <= CNT_ZERO;
          bit_idx_r <= 3'd0;
          if (pop_s) begin
            shift_r <= head_s;
            state_r <= START;
          end
        end
        START: begin
          tx_r   <= 1'b0;
          busy_r <= 1'b1;
          if (bit_end_s) begin
            cnt_r     <= CNT_ZERO;
            bit_idx_r <= 3'd0;
            state_r   <= DATA;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        DATA: begin
          tx_r   <= shift_r[bit_idx_r];
          busy_r <= 1'b1;
          if (bit_end_s) begin
            cnt_r <= CNT_ZERO;
            if (bit_idx_r == 3'd7) begin
              state_r <= STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        STOP: begin
          tx_r   <= 1'b1;
          busy_r <= 1'b1;
          if (bit_end_s) begin
            // Last stop clock: flag it, and chain straight into the next frame if one is queued.
            cnt_r  <= CNT_ZERO;
            done_r <= 1'b1;
            if (pop_s) begin
              shift_r <= head_s;
              state_r <= START;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= CNT_ZERO;
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end
endmodule
